program_loader: RTL and testbench

Program loader for the CPU's instruction store. It accepts a byte stream on a valid/ready interface, assembles WIDTH-bit instruction words, and writes them to consecutive instruction-memory addresses starting at 0. It is the writer side of the instruction fetch path that the CPU's counter reads. It holds the CPU in reset for the whole load and releases it once the final word has been written.

---
 rtl/program_loader_pkg.sv | 21 ++
 rtl/program_loader_word_assembler.sv | 48 ++++
 rtl/program_loader.sv | 154 +++++++++++++++
 tb/tb_program_loader.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/program_loader_pkg.sv
// rtl/program_loader_pkg.sv - shared state encoding, sync byte and word sizing for the program loader

package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LEN_LO,
      LEN_HI,
      DATA,
      CHECK,
      DONE,
      ERROR
   } state_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

   function automatic int bytes_per_word(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/program_loader_word_assembler.sv
// rtl/program_loader_word_assembler.sv - shifts little-endian bytes into a WIDTH-bit word and flags its last byte

module word_assembler
   import program_loader_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             clear,
   input  logic             byte_valid,
   input  logic [7:0]       byte_data,
   output logic [WIDTH-1:0] word_next,
   output logic             word_done
);

   localparam int BYTES_PER_WORD = bytes_per_word(WIDTH);

   logic [7:0] idx;

   assign word_done = byte_valid && (idx == 8'(BYTES_PER_WORD - 1));

   always_ff @(posedge clock) begin
      if (reset || clear) begin
         idx <= 8'd0;
      end else if (byte_valid) begin
         idx <= word_done ? 8'd0 : idx + 8'd1;
      end
   end

   // Only the upper WIDTH-8 bits survive a shift; the arriving byte completes the word combinationally.
   if (WIDTH > 8) begin : g_multi
      logic [WIDTH-9:0] shreg;

      assign word_next = {byte_data, shreg};

      always_ff @(posedge clock) begin
         if (reset || clear) begin
            shreg <= '0;
         end else if (byte_valid) begin
            shreg <= word_next[WIDTH-1:8];
         end
      end
   end else begin : g_single
      assign word_next = byte_data;
   end

endmodule

// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream instruction loader; PROGRAM_LOADER_CHECKSUM_EN adds a trailing checksum byte

module program_loader #(
   parameter int WIDTH         = 16,
   parameter int COUNTER_WIDTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [7:0]               in_data,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     mem_we,
   output logic [COUNTER_WIDTH-1:0] mem_addr,
   output logic [WIDTH-1:0]         mem_wdata,
   output logic                     cpu_reset,
   output logic                     load_done,
   output logic                     load_error
);

   import program_loader_pkg::*;

   state_t                   state;
   logic [7:0]               len_lo;
   logic [15:0]              words_left;
   logic [COUNTER_WIDTH-1:0] addr;
   logic                     accept;
   logic                     restart;
   logic [15:0]              len_n;
   logic                     len_too_big;
   logic                     data_byte;
   logic [WIDTH-1:0]         word_next;
   logic                     word_done;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
   logic [7:0] csum;
   localparam state_t AFTER_DATA = CHECK;
`else
   localparam state_t AFTER_DATA = DONE;
`endif

   assign accept      = in_valid && in_ready;
   assign restart     = accept && (in_data == SYNC_BYTE) &&
                        (state == IDLE || state == DONE || state == ERROR);
   assign len_n       = {in_data, len_lo};
   assign len_too_big = {16'd0, len_n} > (32'd1 << COUNTER_WIDTH);
   assign data_byte   = accept && (state == DATA);

   word_assembler #(.WIDTH(WIDTH)) u_word_assembler (
      .clock      (clock),
      .reset      (reset),
      .clear      (restart),
      .byte_valid (data_byte),
      .byte_data  (in_data),
      .word_next  (word_next),
      .word_done  (word_done)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_reset  <= 1'b1;
         load_done  <= 1'b0;
         load_error <= 1'b0;
         len_lo     <= 8'd0;
         words_left <= 16'd0;
         addr       <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         mem_we   <= 1'b0;
         in_ready <= 1'b1;
         if (restart) begin
            state      <= LEN_LO;
            addr       <= '0;
            cpu_reset  <= 1'b1;
            load_done  <= 1'b0;
            load_error <= 1'b0;
         end else begin
            case (state)
               IDLE: ;
               LEN_LO: if (accept) begin
                  len_lo <= in_data;
                  state  <= LEN_HI;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  csum   <= in_data;
`endif
               end
               LEN_HI: if (accept) begin
                  words_left <= len_n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  csum       <= csum + in_data;
`endif
                  if (len_too_big) begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end else if (len_n == 16'd0) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                     state      <= CHECK;
`else
                     state      <= DONE;
                     cpu_reset  <= 1'b0;
                     load_done  <= 1'b1;
`endif
                  end else begin
                     state      <= DATA;
                  end
               end
               DATA: if (accept) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                  csum <= csum + in_data;
`endif
                  if (word_done) begin
                     mem_we     <= 1'b1;
                     in_ready   <= 1'b0;
                     mem_addr   <= addr;
                     mem_wdata  <= word_next;
                     addr       <= addr + COUNTER_WIDTH'(1);
                     words_left <= words_left - 16'd1;
                     if (words_left == 16'd1) state <= AFTER_DATA;
                  end
               end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
               CHECK: if (accept) begin
                  if (in_data == csum) begin
                     state     <= DONE;
                     cpu_reset <= 1'b0;
                     load_done <= 1'b1;
                  end else begin
                     state      <= ERROR;
                     load_error <= 1'b1;
                  end
               end
`endif
               // Entered on the last word's accept edge, so release lands after the write cycle.
               DONE: begin
                  cpu_reset <= 1'b0;
                  load_done <= 1'b1;
               end
               ERROR: begin
                  cpu_reset  <= 1'b1;
                  load_error <= 1'b1;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader

module tb_program_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  in_data = 8'd0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        cpu_reset;
   logic        load_done;
   logic        load_error;

   int passed = 0;
   int total = 0;
   int wide = 0;
   int base = 0;
   logic prev_we = 1'b0;
   logic [31:0] wr_addr[$];
   logic [31:0] wr_data[$];

   program_loader #(.WIDTH(16), .COUNTER_WIDTH(8)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .cpu_reset  (cpu_reset),
      .load_done  (load_done),
      .load_error (load_error)
   );

   always #5 clock = ~clock;

   always @(negedge clock) begin
      if (!reset && mem_we) begin
         wr_addr.push_back(32'(mem_addr));
         wr_data.push_back(32'(mem_wdata));
         if (prev_we) wide++;
      end
      prev_we = mem_we && !reset;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (n >= 20) chk("ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clock);
      in_valid = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clock);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("rst_load_done", 32'(load_done), 32'd0);
      chk("rst_load_error", 32'(load_error), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

`ifndef PROGRAM_LOADER_CHECKSUM_EN
      // Two-word load: A5 02 00 34 12 CD AB
      base = wr_addr.size();
      send(8'hA5);
      chk("t1_sync_cpu_reset", 32'(cpu_reset), 32'd1);
      send(8'h02); send(8'h00); send(8'h34); send(8'h12);
      chk("t1_w0_we", 32'(mem_we), 32'd1);
      chk("t1_w0_addr", 32'(mem_addr), 32'd0);
      chk("t1_w0_data", 32'(mem_wdata), 32'h1234);
      chk("t1_w0_stall", 32'(in_ready), 32'd0);
      send(8'hCD); send(8'hAB);
      chk("t1_w1_we", 32'(mem_we), 32'd1);
      chk("t1_w1_addr", 32'(mem_addr), 32'd1);
      chk("t1_w1_data", 32'(mem_wdata), 32'hABCD);
      chk("t1_w1_cpu_reset", 32'(cpu_reset), 32'd1);
      @(negedge clock);
      chk("t1_end_we", 32'(mem_we), 32'd0);
      chk("t1_end_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("t1_end_done", 32'(load_done), 32'd1);
      chk("t1_nwr", 32'(wr_addr.size() - base), 32'd2);

      // Garbage then a one-word reload from DONE: 00 FF A5 01 00 EF BE
      base = wr_addr.size();
      send(8'h00); send(8'hFF);
      chk("t2_garbage_nwr", 32'(wr_addr.size() - base), 32'd0);
      chk("t2_garbage_done", 32'(load_done), 32'd1);
      send(8'hA5);
      chk("t2_sync_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("t2_sync_done", 32'(load_done), 32'd0);
      send(8'h01); send(8'h00); send(8'hEF); send(8'hBE);
      chk("t2_addr", 32'(mem_addr), 32'd0);
      chk("t2_data", 32'(mem_wdata), 32'hBEEF);
      @(negedge clock);
      chk("t2_done", 32'(load_done), 32'd1);
      chk("t2_nwr", 32'(wr_addr.size() - base), 32'd1);

      // Oversized length 257 then recovery
      base = wr_addr.size();
      send(8'hA5); send(8'h01); send(8'h01);
      chk("t3_error", 32'(load_error), 32'd1);
      chk("t3_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("t3_done", 32'(load_done), 32'd0);
      send(8'h34); send(8'h12);
      repeat (3) @(negedge clock);
      chk("t3_nwr", 32'(wr_addr.size() - base), 32'd0);
      send(8'hA5);
      chk("t3_sync_clears_error", 32'(load_error), 32'd0);
      send(8'h01); send(8'h00); send(8'h78); send(8'h56);
      @(negedge clock);
      chk("t3_rec_done", 32'(load_done), 32'd1);
      chk("t3_rec_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("t3_rec_addr", wr_addr[base], 32'd0);
      chk("t3_rec_data", wr_data[base], 32'h5678);

      // Stall mid-word
      base = wr_addr.size();
      send(8'hA5); send(8'h01); send(8'h00); send(8'h11);
      repeat (5) @(negedge clock);
      chk("t4_stall_we", 32'(mem_we), 32'd0);
      chk("t4_stall_nwr", 32'(wr_addr.size() - base), 32'd0);
      send(8'h22);
      chk("t4_data", 32'(mem_wdata), 32'h2211);
      @(negedge clock);
      chk("t4_nwr", 32'(wr_addr.size() - base), 32'd1);

      // Zero-length frame releases right after the LEN_HI byte
      base = wr_addr.size();
      send(8'hA5); send(8'h00); send(8'h00);
      chk("t5_cpu_reset", 32'(cpu_reset), 32'd0);
      chk("t5_done", 32'(load_done), 32'd1);
      chk("t5_nwr", 32'(wr_addr.size() - base), 32'd0);

      // Full 256-word frame: last write at 0xFF, counter wrap causes no extra write
      base = wr_addr.size();
      send(8'hA5); send(8'h00); send(8'h01);
      for (int i = 0; i < 256; i++) begin
         send(8'(i));
         send(8'h5A);
      end
      repeat (3) @(negedge clock);
      chk("t6_nwr", 32'(wr_addr.size() - base), 32'd256);
      chk("t6_first_addr", wr_addr[base], 32'd0);
      chk("t6_last_addr", wr_addr[base + 255], 32'hFF);
      chk("t6_last_data", wr_data[base + 255], 32'h5AFF);
      chk("t6_done", 32'(load_done), 32'd1);
      chk("strobe_width", 32'(wide), 32'd0);

      // Reset after one byte of a word
      base = wr_addr.size();
      send(8'hA5); send(8'h01); send(8'h00); send(8'h33);
      reset = 1'b1;
      @(negedge clock);
      chk("t7_in_ready", 32'(in_ready), 32'd0);
      chk("t7_mem_wdata", 32'(mem_wdata), 32'd0);
      chk("t7_mem_addr", 32'(mem_addr), 32'd0);
      chk("t7_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("t7_done", 32'(load_done), 32'd0);
      reset = 1'b0;
      @(negedge clock);
      send(8'h44);
      repeat (3) @(negedge clock);
      chk("t7_nwr", 32'(wr_addr.size() - base), 32'd0);
      chk("t7_still_reset", 32'(cpu_reset), 32'd1);
`else
      // Checksum good: A5 01 00 34 12 47
      base = wr_addr.size();
      send(8'hA5); send(8'h01); send(8'h00); send(8'h34); send(8'h12);
      chk("c1_data", 32'(mem_wdata), 32'h1234);
      @(negedge clock);
      chk("c1_pre_cpu_reset", 32'(cpu_reset), 32'd1);
      send(8'h47);
      chk("c1_done", 32'(load_done), 32'd1);
      chk("c1_cpu_reset", 32'(cpu_reset), 32'd0);

      // Checksum bad: same frame with 48
      base = wr_addr.size();
      send(8'hA5); send(8'h01); send(8'h00); send(8'h34); send(8'h12);
      send(8'h48);
      chk("c2_error", 32'(load_error), 32'd1);
      chk("c2_cpu_reset", 32'(cpu_reset), 32'd1);
      chk("c2_done", 32'(load_done), 32'd0);
      @(negedge clock);
      chk("c2_nwr", 32'(wr_addr.size() - base), 32'd1);
      chk("c2_addr", wr_addr[base], 32'd0);
      chk("c2_wdata", wr_data[base], 32'h1234);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
